// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the L2 port.
// master = arbiter side, slave = caches/L2 side.
interface cache_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   // Request/response semantics: a client raises read/write as a level and
   // holds it, with address/data stable, until its one-cycle resp pulse.
   // On the L2 side the arbiter holds l2_read/l2_write, l2_addr and l2_wdata
   // stable until the single-cycle l2_resp, at which l2_rdata is valid.
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              l2_read;
   logic              l2_write;
   logic [ADDR_W-1:0] l2_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic [LINE_W-1:0] l2_rdata;
   logic              l2_resp;

   modport master (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
      output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
   );

   modport slave (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto the unified L2 line port.
// One transaction at a time; all outputs are registered.
module cache_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int LINE_W     = 128,
   parameter int OFFSET_W   = 4,
   parameter bit D_PRIORITY = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cache_mem_arbiter_if.master   bus,
   output logic [1:0]            dbg_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, DONE = 2'd3} state_t;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

   state_t            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic              l2_read_q, l2_read_d;
   logic              l2_write_q, l2_write_d;
   logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
   logic [LINE_W-1:0] l2_wdata_q, l2_wdata_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_resp_q, i_resp_d;
   logic              d_resp_q, d_resp_d;
   logic              d_req;
   logic              pick_d;

   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      l2_read_d  = l2_read_q;
      l2_write_d = l2_write_q;
      l2_addr_d  = l2_addr_q;
      l2_wdata_d = l2_wdata_q;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      i_resp_d   = 1'b0;
      d_resp_d   = 1'b0;
      d_req      = bus.d_read | bus.d_write;
      // On a tie D wins under fixed priority, or when I was the last grant.
      pick_d     = d_req && (!bus.i_read || D_PRIORITY || !last_d_q);

      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d    = BUSY_D;
               last_d_d   = 1'b1;
               l2_write_d = bus.d_write;
               l2_read_d  = ~bus.d_write;
               l2_addr_d  = bus.d_addr & ALIGN_MASK;
               l2_wdata_d = bus.d_wdata;
            end else if (bus.i_read) begin
               state_d    = BUSY_I;
               last_d_d   = 1'b0;
               l2_read_d  = 1'b1;
               l2_write_d = 1'b0;
               l2_addr_d  = bus.i_addr & ALIGN_MASK;
               l2_wdata_d = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.l2_resp) begin
               state_d    = DONE;
               l2_read_d  = 1'b0;
               l2_write_d = 1'b0;
               if (state_q == BUSY_I) begin
                  i_rdata_d = bus.l2_rdata;
                  i_resp_d  = 1'b1;
               end else begin
                  d_rdata_d = bus.l2_rdata;
                  d_resp_d  = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_d_q   <= 1'b0;
         l2_read_q  <= 1'b0;
         l2_write_q <= 1'b0;
         l2_addr_q  <= '0;
         l2_wdata_q <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         i_resp_q   <= 1'b0;
         d_resp_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_d_q   <= last_d_d;
         l2_read_q  <= l2_read_d;
         l2_write_q <= l2_write_d;
         l2_addr_q  <= l2_addr_d;
         l2_wdata_q <= l2_wdata_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
         i_resp_q   <= i_resp_d;
         d_resp_q   <= d_resp_d;
      end
   end

   assign bus.l2_read  = l2_read_q;
   assign bus.l2_write = l2_write_q;
   assign bus.l2_addr  = l2_addr_q;
   assign bus.l2_wdata = l2_wdata_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.i_resp   = i_resp_q;
   assign bus.d_resp   = d_resp_q;
   assign dbg_state    = state_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: dut0 is round-robin, dut1 has fixed D-cache priority.
module tb_cache_mem_arbiter;
   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY_I = 2'd1, S_BUSY_D = 2'd2, S_DONE = 2'd3;
   localparam logic [127:0] LINE_A = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
   localparam logic [127:0] LINE_W5 = {16{8'hA5}};

   logic clk;
   logic rst_n;
   logic [1:0] dbg0, dbg1;
   int checks = 0;
   int failures = 0;
   int rd_cycles = 0;
   int both_cycles = 0;

   cache_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus0 ();
   cache_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus1 ();

   cache_mem_arbiter #(.ADDR_W(16), .LINE_W(128), .OFFSET_W(4), .D_PRIORITY(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.master), .dbg_state(dbg0));
   cache_mem_arbiter #(.ADDR_W(16), .LINE_W(128), .OFFSET_W(4), .D_PRIORITY(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.master), .dbg_state(dbg1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus0.l2_read) rd_cycles++;
      if ((bus0.l2_read && bus0.l2_write) || (bus1.l2_read && bus1.l2_write)) both_cycles++;
   end

   // dut1's L2 answers in the first cycle it sees a request.
   initial begin
      bus1.l2_resp  = 1'b0;
      bus1.l2_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus1.l2_resp  = bus1.l2_read | bus1.l2_write;
         bus1.l2_rdata = {4{32'h1234_5678}};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for an L2 request on dut0, then answers after lat cycles.
   task automatic serve(input int lat, input logic [127:0] data);
      int n = 0;
      while (!(bus0.l2_read || bus0.l2_write) && n < 20) begin
         step();
         n++;
      end
      check("l2_req_wait", n < 20, 1'b1);
      repeat (lat) step();
      bus0.l2_resp  = 1'b1;
      bus0.l2_rdata = data;
      step();
      bus0.l2_resp  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [127:0] rr_data;
      int rd_before;
      int cyc;
      int last_pulse;
      int pulses;

      rst_n = 1'b1;
      bus0.i_read = 0; bus0.i_addr = '0; bus0.d_read = 0; bus0.d_write = 0;
      bus0.d_addr = '0; bus0.d_wdata = '0; bus0.l2_rdata = '0; bus0.l2_resp = 0;
      bus1.i_read = 0; bus1.i_addr = '0; bus1.d_read = 0; bus1.d_write = 0;
      bus1.d_addr = '0; bus1.d_wdata = '0;
      #2;
      do_reset();

      check("rst_state", dbg0, S_IDLE);
      check("rst_l2_read", bus0.l2_read, 1'b0);
      check("rst_l2_write", bus0.l2_write, 1'b0);
      check("rst_l2_addr", bus0.l2_addr, 16'h0);
      check("rst_l2_wdata", bus0.l2_wdata, 128'h0);
      check("rst_i_resp", bus0.i_resp, 1'b0);
      check("rst_d_resp", bus0.d_resp, 1'b0);
      check("rst_i_rdata", bus0.i_rdata, 128'h0);
      check("rst_d_rdata", bus0.d_rdata, 128'h0);

      // I read, L2 answers 3 cycles after l2_read.
      bus0.i_read = 1'b1; bus0.i_addr = 16'h123A;
      step();
      check("i_rd_state", dbg0, S_BUSY_I);
      check("i_rd_l2_read", bus0.l2_read, 1'b1);
      check("i_rd_l2_write", bus0.l2_write, 1'b0);
      check("i_rd_l2_addr", bus0.l2_addr, 16'h1230);
      serve(3, LINE_A);
      check("i_rd_i_resp", bus0.i_resp, 1'b1);
      check("i_rd_i_rdata", bus0.i_rdata, LINE_A);
      check("i_rd_d_resp", bus0.d_resp, 1'b0);
      check("i_rd_l2_read_off", bus0.l2_read, 1'b0);
      check("i_rd_done_state", dbg0, S_DONE);
      bus0.i_read = 1'b0;
      step();
      check("i_rd_pulse_end", bus0.i_resp, 1'b0);
      check("i_rd_idle", dbg0, S_IDLE);

      // D writeback; changed inputs during BUSY must not leak to L2.
      rd_before = rd_cycles;
      bus0.d_write = 1'b1; bus0.d_addr = 16'h4008; bus0.d_wdata = LINE_W5;
      step();
      check("d_wr_l2_write", bus0.l2_write, 1'b1);
      check("d_wr_l2_addr", bus0.l2_addr, 16'h4000);
      check("d_wr_l2_wdata", bus0.l2_wdata, LINE_W5);
      bus0.d_addr = 16'hFFFF; bus0.d_wdata = '0;
      step();
      check("d_wr_addr_hold", bus0.l2_addr, 16'h4000);
      check("d_wr_wdata_hold", bus0.l2_wdata, LINE_W5);
      serve(1, 128'h5);
      check("d_wr_d_resp", bus0.d_resp, 1'b1);
      check("d_wr_i_resp", bus0.i_resp, 1'b0);
      check("d_wr_l2_write_off", bus0.l2_write, 1'b0);
      check("d_wr_no_read", rd_cycles - rd_before, 0);
      check("i_rdata_hold", bus0.i_rdata, LINE_A);
      bus0.d_write = 1'b0;
      step();

      // Round-robin ties from reset: D, I, D, I.
      do_reset();
      bus0.i_read = 1'b1; bus0.i_addr = 16'h2000;
      bus0.d_read = 1'b1; bus0.d_addr = 16'h3000;
      for (int k = 0; k < 4; k++) begin
         rr_data = {96'h0, 32'hC0DE_0000 + 32'(k)};
         serve(1, rr_data);
         if (k % 2 == 0) begin
            check("rr_d_resp", bus0.d_resp, 1'b1);
            check("rr_i_quiet", bus0.i_resp, 1'b0);
            check("rr_d_rdata", bus0.d_rdata, rr_data);
         end else begin
            check("rr_i_resp", bus0.i_resp, 1'b1);
            check("rr_d_quiet", bus0.d_resp, 1'b0);
            check("rr_i_rdata", bus0.i_rdata, rr_data);
         end
         step();
      end
      bus0.i_read = 1'b0; bus0.d_read = 1'b0;
      step();
      step();

      // D priority on dut1: two D grants, then I once d_read drops.
      bus1.i_read = 1'b1; bus1.i_addr = 16'h0100;
      bus1.d_read = 1'b1; bus1.d_addr = 16'h0200;
      step();
      check("dp_busy_d1", dbg1, S_BUSY_D);
      step();
      check("dp_d_resp1", bus1.d_resp, 1'b1);
      check("dp_i_quiet1", bus1.i_resp, 1'b0);
      step();
      check("dp_idle", dbg1, S_IDLE);
      step();
      check("dp_busy_d2", dbg1, S_BUSY_D);
      step();
      check("dp_d_resp2", bus1.d_resp, 1'b1);
      check("dp_i_quiet2", bus1.i_resp, 1'b0);
      bus1.d_read = 1'b0;
      step();
      step();
      check("dp_busy_i", dbg1, S_BUSY_I);
      step();
      check("dp_i_resp", bus1.i_resp, 1'b1);
      check("dp_d_quiet", bus1.d_resp, 1'b0);
      bus1.i_read = 1'b0;
      step();

      // Reset during BUSY_I, then a stale l2_resp.
      bus0.i_read = 1'b1; bus0.i_addr = 16'h5550;
      step();
      check("mr_busy", dbg0, S_BUSY_I);
      rst_n = 1'b0;
      #1;
      check("mr_state", dbg0, S_IDLE);
      check("mr_l2_read", bus0.l2_read, 1'b0);
      check("mr_l2_addr", bus0.l2_addr, 16'h0);
      check("mr_i_rdata", bus0.i_rdata, 128'h0);
      check("mr_d_rdata", bus0.d_rdata, 128'h0);
      step();
      rst_n = 1'b1;
      bus0.i_read = 1'b0;
      bus0.l2_resp = 1'b1; bus0.l2_rdata = LINE_A;
      step();
      bus0.l2_resp = 1'b0;
      check("mr_no_i_resp", bus0.i_resp, 1'b0);
      check("mr_idle", dbg0, S_IDLE);
      check("mr_rdata_clean", bus0.i_rdata, 128'h0);
      step();
      check("mr_no_i_resp2", bus0.i_resp, 1'b0);

      // Back-to-back D reads, L2 answers in the first BUSY cycle.
      bus0.d_read = 1'b1; bus0.d_addr = 16'h777C;
      cyc = 0; last_pulse = -1; pulses = 0;
      for (int n = 0; n < 12; n++) begin
         step();
         cyc++;
         bus0.l2_resp = bus0.l2_read;
         bus0.l2_rdata = {112'h0, 16'(cyc)};
         if (bus0.l2_read) check("b2b_l2_addr", bus0.l2_addr, 16'h7770);
         if (bus0.d_resp) begin
            if (last_pulse >= 0) check("b2b_gap", cyc - last_pulse, 3);
            last_pulse = cyc;
            pulses++;
         end
      end
      bus0.d_read = 1'b0;
      bus0.l2_resp = 1'b0;
      check("b2b_pulses", pulses, 4);
      step();
      step();
      check("b2b_idle", dbg0, S_IDLE);
      check("never_rd_and_wr", both_cycles, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
